// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter of the Mini MIPS
//   core: FSM state encoding, owner encoding and the arbitration helper.
//   No ports; imported by mem_port_arbiter and by its testbench.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // 2-bit FSM encoding. The order follows the life of one memory access.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Owner encoding, also driven on the owner output.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  // Arbitration rule used in IDLE. Load/store wins whenever it is
  // requesting, unless fetch is also requesting and has already been passed
  // over the maximum number of times in a row.
  function automatic logic ls_wins(input logic if_req,
                                   input logic ls_req,
                                   input logic if_starved);
    return ls_req && !(if_req && if_starved);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-ported unified memory between the instruction-fetch
//   (IF) path and the load/store (LS) path. One access at a time is
//   serialised onto a fixed-latency memory port; read data is returned to
//   the requester that won. LS has priority, a starvation counter guarantees
//   that a pending fetch eventually wins.
//
//   Handshake (both requesters): the requester raises req together with a
//   stable command (addr, and for LS also we/wdata) and holds it until it
//   sees ack. ack is a single-cycle pulse; in that same cycle the owner's
//   rdata carries the read word (loads/fetches only). The command is latched
//   when granted, so a req dropped early still completes with an ack. The
//   requester may drop req, or present a new command, in the cycle after ack;
//   the arbiter is in IDLE in that cycle, so it never double-grants.
//
//   Access timing (MEM_LATENCY = L): request seen in IDLE at cycle N,
//   mem_en at N+1 (ISSUE), WAIT for N+2..N+L+1, read word registered at the
//   end of N+L+1, ack at N+L+2 (RESP), IDLE again at N+L+3.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   if_req/if_addr        fetch read request and address
//   if_ack/if_rdata       fetch completion pulse and fetched word
//   ls_req/ls_we          load/store request, 1 = store
//   ls_addr/ls_wdata      load/store address and store data
//   ls_ack/ls_rdata       load/store completion pulse and load data
//   mem_en/mem_we         memory strobe (one cycle per access) and write enable
//   mem_addr/mem_wdata    latched command towards the memory
//   mem_rdata             memory read data, valid MEM_LATENCY cycles after mem_en
//   busy                  1 in any state other than IDLE
//   owner                 0 = IF, 1 = LS; owner of the current/last access
//   dbg_state             current FSM state
//   dbg_starve            starvation counter, zero-extended to 8 bits
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  // load/store port
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy,
  output logic              owner,
  output arb_state_t        dbg_state,
  output logic [7:0]        dbg_starve
);

  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [LAT_W-1:0] LAT_FIRST = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);

  arb_state_t        state;
  arb_state_t        next_state;

  logic [LAT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic              cmd_we;

  logic              any_req;
  logic              grant_ls;
  logic              lat_done;
  logic              capture;

  // ---------------------------------------------------------------------------
  // Arbitration decision, only acted on in IDLE.
  // ---------------------------------------------------------------------------
  assign any_req  = if_req | ls_req;
  assign grant_ls = ls_wins(if_req, ls_req, starve_cnt == STV_MAX);

  // lat_cnt counts the WAIT cycles 1..MEM_LATENCY; the last one is the cycle
  // in which mem_rdata is valid.
  assign lat_done = (lat_cnt == LAT_LAST);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    if_ack     = 1'b0;
    ls_ack     = 1'b0;
    busy       = 1'b1;
    capture    = 1'b0;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          next_state = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = cmd_we;
        next_state = ST_WAIT;
      end

      ST_WAIT: begin
        if (lat_done) begin
          capture    = 1'b1;
          next_state = ST_RESP;
        end
      end

      ST_RESP: begin
        if_ack     = (owner == OWNER_IF);
        ls_ack     = (owner == OWNER_LS);
        next_state = ST_IDLE;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, latency counter, starvation counter, read-data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWNER_IF;
      cmd_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            if (grant_ls) begin
              owner     <= OWNER_LS;
              cmd_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
            end else begin
              owner    <= OWNER_IF;
              cmd_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end

          // Starvation only accumulates while fetch is actually waiting.
          // An IDLE cycle without a fetch request, or a fetch grant, resets it.
          if (!if_req) begin
            starve_cnt <= '0;
          end else if (grant_ls) begin
            if (starve_cnt != STV_MAX) begin
              starve_cnt <= starve_cnt + STV_W'(1);
            end
          end else begin
            starve_cnt <= '0;
          end
        end

        ST_ISSUE: begin
          lat_cnt <= LAT_FIRST;
        end

        ST_WAIT: begin
          if (!lat_done) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
          // Only the owner's register moves; a store leaves ls_rdata alone.
          if (capture) begin
            if (owner == OWNER_IF) begin
              if_rdata <= mem_rdata;
            end else if (!cmd_we) begin
              ls_rdata <= mem_rdata;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign dbg_state  = state;
  assign dbg_starve = 8'(starve_cnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
//   A behavioural memory answers mem[addr] two cycles after mem_en. Expected
//   read data comes from a separate reference memory updated when stimulus is
//   driven and is queued per requester; the monitor pops on every ack.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_d = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_ack;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;
  arb_state_t    dbg_state;
  logic [7:0]    dbg_starve;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // ---------------------------------------------------------------------------
  // Behavioural memory: unwritten words read as init_val(addr)
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  bit [DW-1:0] mem_arr [0:4095];
  bit          mem_wr  [0:4095];
  bit [DW-1:0] rd_p1;
  bit [DW-1:0] rd_p2;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[11:0]] <= mem_wdata;
      mem_wr[mem_addr[11:0]]  <= 1'b1;
    end
    // Filler pattern outside the valid slot exposes a mistimed capture.
    if (mem_en) begin
      rd_p1 <= mem_wr[mem_addr[11:0]] ? mem_arr[mem_addr[11:0]] : init_val(mem_addr);
    end else begin
      rd_p1 <= 32'hBAD0_0BAD;
    end
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  // Reference memory for expected values, updated when stimulus is driven.
  bit [DW-1:0] ref_arr [0:4095];
  bit          ref_wr  [0:4095];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_wr[a[11:0]] ? ref_arr[a[11:0]] : init_val(a);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [DW:0] if_exp_q[$];   // {unused, data}
  logic [DW:0] ls_exp_q[$];   // {is_store, data}
  logic        grant_log[$];  // 1 = LS, 0 = IF, one entry per mem_en

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor (samples on negedge)
  // ---------------------------------------------------------------------------
  int            en_cnt = 0;
  int            en_cyc = 0;
  logic          en_we;
  logic [AW-1:0] en_addr;
  logic [DW-1:0] en_wdata;
  int            if_ack_cnt = 0;
  int            ls_ack_cnt = 0;
  int            busy_cnt = 0;
  logic [DW-1:0] prev_if = '0;
  logic [DW-1:0] prev_ls = '0;

  initial begin
    logic        cls;
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      chk("ack_exclusive", {1'b0, if_ack & ls_ack}, 0);
      if (mem_en) begin
        en_cnt++;
        en_cyc   = cyc;
        en_we    = mem_we;
        en_addr  = mem_addr;
        en_wdata = mem_wdata;
        // IF traffic lives below 0x800 (except 0x20, an LS address).
        cls = (mem_addr >= 32'h800) || (mem_addr == 32'h20);
        grant_log.push_back(cls);
        chk("owner_at_issue", {63'd0, owner}, {63'd0, cls});
        if (!cls) chk("starve_clear_on_if", dbg_starve, 0);
      end
      if (if_ack) begin
        if_ack_cnt++;
        if (if_exp_q.size() == 0) begin
          chk("if_ack_unexpected", 1, 0);
        end else begin
          e = if_exp_q.pop_front();
          chk("if_rdata", if_rdata, e[DW-1:0]);
        end
      end else if (!rst_d) begin
        chk("if_rdata_hold", if_rdata, prev_if);
      end
      if (ls_ack) begin
        ls_ack_cnt++;
        if (ls_exp_q.size() == 0) begin
          chk("ls_ack_unexpected", 1, 0);
        end else begin
          e = ls_exp_q.pop_front();
          if (e[DW]) chk("ls_rdata_store_hold", ls_rdata, prev_ls);
          else       chk("ls_rdata", ls_rdata, e[DW-1:0]);
        end
      end else if (!rst_d) begin
        chk("ls_rdata_hold", ls_rdata, prev_ls);
      end
      prev_if = if_rdata;
      prev_ls = ls_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Each access task returns at the negedge of the ack cycle with
  // req still high; the caller then either starts another access or drops req,
  // both of which land in the following (IDLE) cycle.
  // ---------------------------------------------------------------------------
  task automatic if_access(input logic [AW-1:0] a, output int start, output int ack_at);
    bit got;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = a;
    start   = cyc;
    if_exp_q.push_back({1'b0, ref_read(a)});
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = if_ack;
    end
    ack_at = cyc;
    if (!got) chk("if_ack_timeout", 0, 1);
  endtask

  task automatic ls_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int start, output int ack_at);
    bit got;
    @(posedge clk); #1;
    ls_req   = 1'b1;
    ls_we    = we;
    ls_addr  = a;
    ls_wdata = d;
    start    = cyc;
    ls_exp_q.push_back({we, we ? '0 : ref_read(a)});
    if (we) begin
      ref_arr[a[11:0]] = d;
      ref_wr[a[11:0]]  = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = ls_ack;
    end
    ack_at = cyc;
    if (!got) chk("ls_ack_timeout", 0, 1);
  endtask

  task automatic if_drop();
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic ls_drop();
    @(posedge clk); #1;
    ls_req = 1'b0;
  endtask

  task automatic drop_all();
    @(posedge clk); #1;
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {58'd0, if_ack, ls_ack, mem_en, mem_we, busy, owner}, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ls_rdata"}, ls_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_starve"}, dbg_starve, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int s, a, s_if, a_if, s_ls, a_ls, n0, n1, n2, b0;
  logic exp_order[$];

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // T1: single fetch, N+1 issue, N+4 ack
    n0 = if_ack_cnt;
    if_access(32'h10, s, a);
    chk("t1_en_cycle", en_cyc, s + 1);
    chk("t1_en_we", {63'd0, en_we}, 0);
    chk("t1_en_addr", en_addr, 32'h10);
    chk("t1_ack_cycle", a, s + 4);
    chk("t1_rdata", if_rdata, init_val(32'h10));
    if_drop();
    repeat (4) @(negedge clk);
    chk("t1_one_ack", if_ack_cnt - n0, 1);

    // T2: store then load the same word
    ls_access(1'b1, 32'h20, 32'hDEAD_BEEF, s, a);
    chk("t2_en_cycle", en_cyc, s + 1);
    chk("t2_en_we", {63'd0, en_we}, 1);
    chk("t2_en_wdata", en_wdata, 32'hDEAD_BEEF);
    chk("t2_ack_cycle", a, s + 4);
    ls_drop();
    ls_access(1'b0, 32'h20, 32'h0, s, a);
    chk("t2_load_back", ls_rdata, 32'hDEAD_BEEF);
    ls_drop();
    repeat (3) @(posedge clk);

    // T3: both requesters held continuously
    grant_log.delete();
    exp_order.delete();
    for (int g = 0; g < 15; g++) exp_order.push_back((g % 5) != 4);
    fork
      begin
        for (int i = 0; i < 3; i++) if_access(32'h100 + 4 * i, s_if, a_if);
        if_drop();
      end
      begin
        for (int i = 0; i < 12; i++) ls_access(1'b0, 32'h800 + 4 * i, 32'h0, s_ls, a_ls);
        ls_drop();
      end
    join
    chk("t3_grant_count", grant_log.size(), 15);
    for (int g = 0; g < 15 && g < grant_log.size(); g++)
      chk($sformatf("t3_grant_%0d", g), {63'd0, grant_log[g]}, {63'd0, exp_order[g]});
    repeat (3) @(negedge clk);
    chk("t3_starve_idle", dbg_starve, 0);

    // T4: both rise together with a clear starve counter -> LS first.
    // IF is seen in the IDLE cycle after the LS ack, so its ack is 1+4 later.
    grant_log.delete();
    fork
      begin ls_access(1'b0, 32'h850, 32'h0, s_ls, a_ls); ls_drop(); end
      begin if_access(32'h180, s_if, a_if); if_drop(); end
    join
    chk("t4_ls_ack", a_ls, s_ls + 4);
    chk("t4_if_ack", a_if, a_ls + 5);
    chk("t4_grants", grant_log.size(), 2);
    if (grant_log.size() == 2)
      chk("t4_order", {62'd0, grant_log[0], grant_log[1]}, 2'b10);
    repeat (2) @(posedge clk);

    // T5: reset during WAIT drops the access
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h840;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_in_wait", dbg_state, ST_WAIT);
    reset = 1'b1; ls_req = 1'b0;
    n0 = if_ack_cnt; n1 = ls_ack_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("t5");
    repeat (6) @(negedge clk);
    chk("t5_no_ack", (if_ack_cnt - n0) + (ls_ack_cnt - n1), 0);
    ls_access(1'b0, 32'h844, 32'h0, s, a);
    chk("t5_after_ack", a, s + 4);
    ls_drop();

    // T6: drop the cycle after ack, then re-request
    n2 = en_cnt; b0 = busy_cnt;
    for (int i = 0; i < 3; i++) begin
      ls_access(1'b0, 32'h860 + 4 * i, 32'h0, s, a);
      chk("t6_ack_cycle", a, s + 4);
      ls_drop();
      @(negedge clk);
      chk("t6_idle_busy", {63'd0, busy}, 0);
    end
    chk("t6_one_en_each", en_cnt - n2, 3);
    chk("t6_busy_cycles", busy_cnt - b0, 12);

    // Protocol violation: fetch req pulsed for one cycle still completes.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h140; s = cyc;
    if_exp_q.push_back({1'b0, ref_read(32'h140)});
    @(posedge clk); #1;
    if_req = 1'b0;
    a = -1;
    for (int k = 0; k < 20 && a < 0; k++) begin
      @(negedge clk);
      if (if_ack) a = cyc;
    end
    chk("pv_ack_cycle", a, s + 4);

    // Random serial traffic
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: if_access(32'h100 + 4 * $urandom_range(0, 63), s, a);
        1: ls_access(1'b1, 32'h800 + 4 * $urandom_range(0, 15), $urandom, s, a);
        default: ls_access(1'b0, 32'h800 + 4 * $urandom_range(0, 15), 32'h0, s, a);
      endcase
      chk("rnd_ack_cycle", a, s + 4);
      drop_all();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (8) @(negedge clk);
    chk("if_queue_empty", if_exp_q.size(), 0);
    chk("ls_queue_empty", ls_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
